fma_issue_ctrl: RTL and testbench
=================================

# fma_issue_ctrl

Issue controller and arbiter for the single-precision FMA pipeline. Shares one FMA datapath between two requesters using round-robin arbitration and a valid/ready handshake. Tracks each operation's source and tag through a fixed-latency shadow pipeline. Buffers results in a credit-protected FIFO, so a stalled consumer never causes a result to be dropped.

## Interface
- `LAT`, default 3: cycles from operands on `fma_a/b/c` to result on `fma_r`; legal range 1..8.
- `FIFO_DEPTH`, default 4: result FIFO entries and total credits; must be a power of two, at least 2.
- `TAG_W`, default 4: width of the requester tag.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 is accepted this cycle.
- `req0_a`, `req0_b`, `req0_c`  in  32  operands for A*B+C.
- `req0_tag`  in  TAG_W  tag, returned with the result.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_c`, `req1_tag`: same as requester 0, for requester 1.
- `fma_a`, `fma_b`, `fma_c`  out  32  registered operands to the FMA pipeline.
- `fma_issue`  out  1  `fma_a/b/c` carry a live operation this cycle.
- `fma_r`  in  32  FMA result, valid LAT cycles after the matching `fma_issue`.
- `res_valid`  out  1  result FIFO not empty.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  32  head result.
- `res_src`  out  1  requester index of the head result.
- `res_tag`  out  TAG_W  tag of the head result.
- `busy`  out  1  any operation in flight or buffered.

## Operation
- Credits:
  - Counter `credit` is set to FIFO_DEPTH at reset.
  - Decrements on an issue and increments on a FIFO pop.
  - A simultaneous issue and pop leaves it unchanged.
  - Invariant: `credit` + in-flight count + FIFO occupancy = FIFO_DEPTH.
- Arbitration:
  - A requester is eligible when its valid is high and `credit` > 0.
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant goes to the requester not granted last. `last_grant` resets to 1, so requester 0 wins first.
  - `last_grant` updates only on an actual issue.
- `reqN_ready` is high only for the granted requester. It may depend combinationally on `req0_valid`/`req1_valid` and `credit`. At most one ready is high per cycle.
- Issue: a handshake (valid & ready) at edge t registers that requester's operands into `fma_a/b/c` and sets `fma_issue`=1 after edge t.
- With no issue, `fma_issue`=0 and `fma_a/b/c` hold their previous values.
- Shadow pipeline:
  - LAT-deep shift register of {valid, src, tag}, loaded in parallel with `fma_a/b/c`, advancing every cycle.
  - When the tail entry is valid, {`fma_r`, src, tag} is pushed into the FIFO that cycle.
  - The FMA datapath has no stall, so the shadow pipeline never stalls.
- Result FIFO:
  - First-word fall-through; `res_*` show the head entry.
  - Pop on `res_valid` & `res_ready`.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by the credit invariant.
- `busy` = (`credit` != FIFO_DEPTH).

## Timing
- Reset values (`rst`=0, asynchronous): all outputs 0, FIFO empty, shadow pipeline invalid, `credit`=FIFO_DEPTH, `last_grant`=1.
- A reset mid-operation discards every in-flight and buffered result.
- Latency from request handshake at edge t:
  - Operands visible on `fma_a/b/c` in cycle t+1.
  - Result pushed in cycle t+1+LAT.
  - `res_valid` high from cycle t+2+LAT if the FIFO was empty.
- Throughput: one issue per cycle while `credit` > 0, alternating when both requesters stay valid.
- Credit zero: both readies are low. A pop at edge t restores eligibility for cycle t+1, not cycle t.
- Results leave in issue order; there is no reordering between requesters.

## Configuration
- `FMA_ISSUE_CTRL_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` [31:0], reset 0.
  - Increments each cycle where `req0_valid`|`req1_valid` is high and `credit`==0.
  - Saturates at 0xFFFFFFFF.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Single op: LAT=3, req0 issues A=0x3F800000, tag 5; model `fma_r` as an LAT-cycle delay returning 0x40000000. Required: `fma_issue` in cycle 1, result pushed in cycle 4, `res_valid` in cycle 5 with `res_data`=0x40000000, `res_src`=0, `res_tag`=5.
- Contention: both requesters hold valid for 6 cycles with `res_ready`=1. Required grant order 0,1,0,1,0,1, with exactly one ready per cycle.
- Backpressure: `res_ready`=0, req0 valid continuously. Required: exactly FIFO_DEPTH=4 issues, then ready low. A single pop re-enables exactly one issue, one cycle later. No result is lost.
- Simultaneous push and pop: at steady state with `res_ready`=1 and continuous issues, FIFO occupancy and `credit` stay constant. Results arrive in issue order with correct tags.
- Reset mid-flight: assert `rst`=0 with 2 ops in flight and 2 buffered. Required: outputs 0 immediately, `credit`=4, `busy`=0, and no stale `res_valid` after release.
- With `FMA_ISSUE_CTRL_STALL_CNT_EN`: repeat the backpressure test for 10 blocked cycles. Required: `stall_cnt`=10.

Source files
------------

// File: rtl/fma_issue_ctrl.sv
// Round-robin issue controller sharing one FMA pipeline between two requesters, with a credit-protected result FIFO.
// Optional feature: define FMA_ISSUE_CTRL_STALL_CNT_EN to add the stall_cnt output.
module fma_issue_ctrl #(
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req0_c,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [31:0]      req1_c,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [31:0]      fma_c,
  output logic             fma_issue,
  input  logic [31:0]      fma_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
`ifdef FMA_ISSUE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CREDIT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]      data;
    logic             src;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [CW-1:0]    credit_q, credit_d;
  logic             last_grant_q, last_grant_d;
  logic             fma_issue_q, fma_issue_d;
  logic [31:0]      fma_a_q, fma_a_d;
  logic [31:0]      fma_b_q, fma_b_d;
  logic [31:0]      fma_c_q, fma_c_d;
  logic             iss_src_q, iss_src_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic [LAT-1:0]   sh_valid_q, sh_valid_d;
  logic [LAT-1:0]   sh_src_q, sh_src_d;
  logic [TAG_W-1:0] sh_tag_q [LAT];
  logic [TAG_W-1:0] sh_tag_d [LAT];
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic   elig0, elig1, grant0, grant1, issue, push, pop;
  entry_t head;

  // Ties go to the requester that did not win the previous issue.
  always_comb begin
    elig0  = req0_valid && (credit_q != '0);
    elig1  = req1_valid && (credit_q != '0);
    grant1 = elig1 && (!elig0 || !last_grant_q);
    grant0 = elig0 && !grant1;
    issue  = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign res_valid = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign res_data  = res_valid ? head.data : '0;
  assign res_src   = res_valid ? head.src  : 1'b0;
  assign res_tag   = res_valid ? head.tag  : '0;
  assign push      = sh_valid_q[LAT-1];
  assign pop       = res_valid && res_ready;
  assign busy      = (credit_q != FULL_CREDIT);

  assign fma_a     = fma_a_q;
  assign fma_b     = fma_b_q;
  assign fma_c     = fma_c_q;
  assign fma_issue = fma_issue_q;

  // The shadow pipeline trails the operand register so its tail lines up with fma_r.
  always_comb begin
    fma_issue_d  = issue;
    fma_a_d      = fma_a_q;
    fma_b_d      = fma_b_q;
    fma_c_d      = fma_c_q;
    iss_src_d    = iss_src_q;
    iss_tag_d    = iss_tag_q;
    last_grant_d = last_grant_q;
    if (issue) begin
      fma_a_d      = grant1 ? req1_a   : req0_a;
      fma_b_d      = grant1 ? req1_b   : req0_b;
      fma_c_d      = grant1 ? req1_c   : req0_c;
      iss_tag_d    = grant1 ? req1_tag : req0_tag;
      iss_src_d    = grant1;
      last_grant_d = grant1;
    end
    sh_valid_d[0] = fma_issue_q;
    sh_src_d[0]   = iss_src_q;
    sh_tag_d[0]   = iss_tag_q;
    for (int i = 1; i < LAT; i++) begin
      sh_valid_d[i] = sh_valid_q[i-1];
      sh_src_d[i]   = sh_src_q[i-1];
      sh_tag_d[i]   = sh_tag_q[i-1];
    end
    credit_d = credit_q - {{(CW-1){1'b0}}, issue} + {{(CW-1){1'b0}}, pop};
  end

  // Credits guarantee a free slot for every push, so no full check is needed.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: fma_r, src: sh_src_q[LAT-1], tag: sh_tag_q[LAT-1]};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q     <= FULL_CREDIT;
      last_grant_q <= 1'b1;
      fma_issue_q  <= 1'b0;
      fma_a_q      <= '0;
      fma_b_q      <= '0;
      fma_c_q      <= '0;
      iss_src_q    <= 1'b0;
      iss_tag_q    <= '0;
      sh_valid_q   <= '0;
      sh_src_q     <= '0;
      for (int i = 0; i < LAT; i++) sh_tag_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      credit_q     <= credit_d;
      last_grant_q <= last_grant_d;
      fma_issue_q  <= fma_issue_d;
      fma_a_q      <= fma_a_d;
      fma_b_q      <= fma_b_d;
      fma_c_q      <= fma_c_d;
      iss_src_q    <= iss_src_d;
      iss_tag_q    <= iss_tag_d;
      sh_valid_q   <= sh_valid_d;
      sh_src_q     <= sh_src_d;
      for (int i = 0; i < LAT; i++) sh_tag_q[i] <= sh_tag_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

`ifdef FMA_ISSUE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where someone wants to issue but all credits are held; saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((req0_valid || req1_valid) && (credit_q == '0) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Self-checking bench for fma_issue_ctrl: queue-based reference model, directed scenarios and random traffic.
// Stall counter checks are included when FMA_ISSUE_CTRL_STALL_CNT_EN is defined.
module tb_fma_issue_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req0_c = '0;
  logic [31:0] req1_a = '0, req1_b = '0, req1_c = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic [31:0] fma_a, fma_b, fma_c, fma_r;
  logic        fma_issue;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_src;
  logic [3:0]  res_tag;
  logic        busy;
`ifdef FMA_ISSUE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fma_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_tag(req1_tag),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_issue(fma_issue),
    .fma_r(fma_r),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_src(res_src), .res_tag(res_tag),
    .busy(busy)
`ifdef FMA_ISSUE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in arithmetic for the FMA: 1*1+1 gives 2.0, anything else a cheap mix.
  function automatic logic [31:0] fake_fma(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    if (a == 32'h3F800000 && b == 32'h3F800000 && c == 32'h3F800000) return 32'h40000000;
    return (a ^ {b[15:0], b[31:16]}) + c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge so they are stable for the whole cycle.
  task automatic applyStimulus(input logic v0, input logic v1, input logic rr);
    @(posedge clk);
    #1;
    req0_valid = v0;
    req1_valid = v1;
    res_ready  = rr;
    req0_a = $urandom(); req0_b = $urandom(); req0_c = $urandom();
    req1_a = $urandom(); req1_b = $urandom(); req1_c = $urandom();
    req0_tag = 4'($urandom_range(0, 15));
    req1_tag = 4'($urandom_range(0, 15));
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, busy, 1'b0);
  endtask

  // Fake FMA: fma_r during cycle m is the result of the operands shown in cycle m-LAT.
  logic [31:0] dly [LAT+1];
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) dly[i] = dly[i-1];
    dly[0] = fake_fma(fma_a, fma_b, fma_c);
    fma_r  = dly[LAT];
  end

  // Reference model: every accepted op sits in one queue until popped, tagged with the
  // cycle it becomes visible at the FIFO head. Credits are simply DEPTH minus queue size.
  typedef struct {
    logic [31:0] data;
    logic        src;
    logic [3:0]  tag;
    int          avail;
  } exp_t;

  exp_t        mq[$];
  int          cyc = 0;
  logic        lg = 1'b1;
  logic        exp_issue = 1'b0;
  logic [31:0] exp_a = '0, exp_b = '0, exp_c = '0;
  logic        g0, g1, mrv;
  int          credit;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      lg        = 1'b1;
      exp_issue = 1'b0;
      exp_a = '0; exp_b = '0; exp_c = '0;
    end else begin
      credit = DEPTH - mq.size();
      g1  = req1_valid && credit > 0 && (!(req0_valid && credit > 0) || lg == 1'b0);
      g0  = req0_valid && credit > 0 && !g1;
      mrv = (mq.size() > 0) && (mq[0].avail <= cyc);
      checkOutput("req0_ready", req0_ready, g0);
      checkOutput("req1_ready", req1_ready, g1);
      checkOutput("fma_issue", fma_issue, exp_issue);
      checkOutput("fma_a", fma_a, exp_a);
      checkOutput("fma_b", fma_b, exp_b);
      checkOutput("fma_c", fma_c, exp_c);
      checkOutput("busy", busy, mq.size() != 0);
      checkOutput("res_valid", res_valid, mrv);
      if (mrv) begin
        checkOutput("res_data", res_data, mq[0].data);
        checkOutput("res_src", res_src, mq[0].src);
        checkOutput("res_tag", res_tag, mq[0].tag);
      end
      if (mrv && res_ready) void'(mq.pop_front());
      exp_issue = g0 || g1;
      if (g0 || g1) begin
        exp_a = g1 ? req1_a : req0_a;
        exp_b = g1 ? req1_b : req0_b;
        exp_c = g1 ? req1_c : req0_c;
        mq.push_back('{data: fake_fma(exp_a, exp_b, exp_c), src: g1,
                       tag: g1 ? req1_tag : req0_tag, avail: cyc + 2 + LAT});
        lg = g1;
      end
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  int          grants[$];
  int          n, issues;
  logic [31:0] first_res;

  initial begin
    // Reset values
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_fma_issue", fma_issue, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fma_a", fma_a, 32'h0);
`ifdef FMA_ISSUE_CTRL_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    @(negedge clk);
    #2 rst = 1'b1;

    // Contention straight after reset: last_grant=1, so requester 0 wins first
    n = 0;
    while (grants.size() < 6 && n < 40) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("one_ready", req0_ready && req1_ready, 1'b0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      n++;
    end
    checkOutput("grant_count", grants.size(), 6);
    foreach (grants[i]) checkOutput($sformatf("grant%0d", i), grants[i], i % 2);
    waitIdle("contention_drain");

    // Single operation, req0, tag 5
    applyStimulus(1'b1, 1'b0, 1'b1);
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_c = 32'h3F800000; req0_tag = 4'd5;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("single_issue", fma_issue, 1'b1);
    checkOutput("single_a", fma_a, 32'h3F800000);
    repeat (LAT) @(posedge clk);
    #1;
    checkOutput("single_early", res_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("single_valid", res_valid, 1'b1);
    checkOutput("single_data", res_data, 32'h40000000);
    checkOutput("single_src", res_src, 1'b0);
    checkOutput("single_tag", res_tag, 4'd5);
    waitIdle("single_drain");

    // Backpressure: 4 issues, then 10 blocked cycles
    doReset();
    issues = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (req0_ready) issues++;
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
`ifdef FMA_ISSUE_CTRL_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 32'd10);
`endif
    @(negedge clk);
    checkOutput("bp_issues", issues, 4);
    checkOutput("bp_pop_cycle_ready", req0_ready, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_after_pop_ready", req0_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_reblocked", req0_ready, 1'b0);
    waitIdle("bp_drain");

    // Reset with two ops buffered and two in flight
    doReset();
    n = 0;
    first_res = '0;
    for (int i = 0; i < 10 && n < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (n == 0) first_res = fake_fma(req0_a, req0_b, req0_c);
      @(negedge clk);
      if (req0_ready) n++;
    end
    checkOutput("mid_issues", n, 4);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_busy_before", busy, 1'b1);
    checkOutput("mid_valid_before", res_valid, 1'b1);
    checkOutput("mid_data_before", res_data, first_res);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", res_valid, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_issue", fma_issue, 1'b0);
    checkOutput("mid_rst_fma_a", fma_a, 32'h0);
    checkOutput("mid_rst_data", res_data, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (LAT + 4) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("mid_no_stale_valid", res_valid, 1'b0);
    checkOutput("mid_no_stale_busy", busy, 1'b0);

    // Random traffic, including long runs of simultaneous push and pop
    for (int i = 0; i < 400; i++) begin
      if (i < 100)
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      else
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) != 0));
    end
    waitIdle("random_drain");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
